// File: rtl/fetch_stage_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage_ctrl
//  Purpose  : Fetch-side consumer of the hazard controls. Owns the PC register
//             and the IF/ID pipeline register, applies branch (execute) and
//             PC-write (writeback) redirects, tracks boot / pending-PC-write
//             phases with a small FSM and counts stall / flush cycles with
//             saturating counters.
//  Ports    : clk, rst                      - clock, sync active-high reset
//             StallF, StallD, FlushD        - hazard controls
//             BranchTakenE, BranchTargetE   - execute-stage redirect
//             PCSrcW, ResultW               - writeback-stage redirect
//             InstrF                        - imem read data for PCF
//             PCF                           - fetch address
//             InstrD, PCD, PCPlus4D, ValidD - IF/ID register contents
//             FetchState                    - 00 BOOT, 01 RUN, 10 PCWAIT
//             StallCnt, FlushCnt            - saturating event counters
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_stage_ctrl #(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               StallF,
  input  logic               StallD,
  input  logic               FlushD,
  input  logic               BranchTakenE,
  input  logic [ADDR_W-1:0]  BranchTargetE,
  input  logic               PCSrcW,
  input  logic [ADDR_W-1:0]  ResultW,
  input  logic [INSTR_W-1:0] InstrF,
  output logic [ADDR_W-1:0]  PCF,
  output logic [INSTR_W-1:0] InstrD,
  output logic [ADDR_W-1:0]  PCD,
  output logic [ADDR_W-1:0]  PCPlus4D,
  output logic               ValidD,
  output logic [1:0]         FetchState,
  output logic [CNT_W-1:0]   StallCnt,
  output logic [CNT_W-1:0]   FlushCnt
);

  typedef enum logic [1:0] {
    ST_BOOT   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PCWAIT = 2'b10
  } state_t;

  localparam logic [ADDR_W-1:0] C_PC_INC  = ADDR_W'(4);
  localparam logic [CNT_W-1:0]  C_CNT_MAX = '1;
  localparam logic [CNT_W-1:0]  C_CNT_ONE = CNT_W'(1);

  state_t               state_q,     state_d;
  logic [ADDR_W-1:0]    pc_q,        pc_d;
  logic [INSTR_W-1:0]   instr_q,     instr_d;
  logic [ADDR_W-1:0]    pcd_q,       pcd_d;
  logic [ADDR_W-1:0]    pcplus4_q,   pcplus4_d;
  logic                 valid_q,     valid_d;
  logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]     flush_cnt_q, flush_cnt_d;

  logic [ADDR_W-1:0]    pc_plus4;
  logic                 redirect;
  logic                 in_boot;

  always_comb begin
    pc_plus4    = pc_q + C_PC_INC;
    redirect    = BranchTakenE | PCSrcW;
    in_boot     = (state_q == ST_BOOT);

    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    pcd_d       = pcd_q;
    pcplus4_d   = pcplus4_q;
    valid_d     = valid_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    // PC: redirects beat the stall; branch beats writeback. BOOT holds the PC
    // so the first fetch of RESET_PC gets a full cycle to settle.
    if (!in_boot) begin
      if (BranchTakenE)  pc_d = BranchTargetE;
      else if (PCSrcW)   pc_d = ResultW;
      else if (!StallF)  pc_d = pc_plus4;
    end

    // IF/ID register: StallD wins over FlushD; BOOT inserts a bubble.
    if (in_boot) begin
      instr_d = '0;
      valid_d = 1'b0;
    end else if (!StallD) begin
      if (FlushD) begin
        instr_d = '0;
        valid_d = 1'b0;
      end else begin
        instr_d   = InstrF;
        pcd_d     = pc_q;
        pcplus4_d = pc_plus4;
        // While a PC write is pending the fetched word is never trusted.
        valid_d   = (state_q != ST_PCWAIT);
      end
    end

    if (!in_boot && StallF && (stall_cnt_q != C_CNT_MAX))
      stall_cnt_d = stall_cnt_q + C_CNT_ONE;
    if (!in_boot && FlushD && !StallD && (flush_cnt_q != C_CNT_MAX))
      flush_cnt_d = flush_cnt_q + C_CNT_ONE;

    case (state_q)
      ST_BOOT:   state_d = ST_RUN;
      ST_RUN:    if (StallF && !StallD && !redirect) state_d = ST_PCWAIT;
      ST_PCWAIT: if (redirect) state_d = ST_RUN;
      default:   state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_BOOT;
      pc_q        <= RESET_PC;
      instr_q     <= '0;
      pcd_q       <= '0;
      pcplus4_q   <= '0;
      valid_q     <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      pcd_q       <= pcd_d;
      pcplus4_q   <= pcplus4_d;
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign PCF        = pc_q;
  assign InstrD     = instr_q;
  assign PCD        = pcd_q;
  assign PCPlus4D   = pcplus4_q;
  assign ValidD     = valid_q;
  assign FetchState = state_q;
  assign StallCnt   = stall_cnt_q;
  assign FlushCnt   = flush_cnt_q;

endmodule
`default_nettype wire
